// File: rtl/power_gauge_ctrl.sv
// power_gauge_ctrl: shot-power gauge for FORTRESS.
// Sweeps a 16-step triangle position and drives a thermometer LED bar.
// Latches a 3-bit power level on fire, or on auto-lock after MAX_SWEEPS
// sweeps, and presents it downstream on a valid/ready handshake.
// Optional build macro: GAUGE_ATTRACT_EN (IDLE attract animation).
//
// Handshake: shot_valid rises with the lock and holds, together with a
// stable power/timeout, until a cycle where shot_valid & shot_ready are
// both high. The transfer happens on that edge, and shot_valid is low
// from the following cycle.
module power_gauge_ctrl #(
  parameter int TICK_DIV   = 4,
  parameter int MAX_SWEEPS = 3
) (
  input  logic       CLK,
  input  logic       nrst,
  input  logic       tick_in,
  input  logic       btn_start,
  input  logic       btn_fire,
  input  logic       shot_ready,
  output logic       led_en,
  output logic [3:0] pos,
  output logic [7:0] bar,
  output logic [2:0] power,
  output logic       shot_valid,
  output logic       timeout,
  output logic [1:0] state
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(MAX_SWEEPS + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SWEEP_MAX = SW'(MAX_SWEEPS);

`ifdef GAUGE_ATTRACT_EN
  localparam bit ATTRACT = 1'b1;
`else
  localparam bit ATTRACT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    LOCK  = 2'd2,
    BAD   = 2'd3
  } st_t;

  st_t           st;
  logic [DW-1:0] div_cnt;
  logic [SW-1:0] sweep_cnt;
  logic [SW-1:0] sweep_inc;
  logic          tick_prev;
  logic          start_prev;
  logic          fire_prev;
  logic          rise_tick;
  logic          rise_start;
  logic          rise_fire;

  assign rise_tick  = tick_in   & ~tick_prev;
  assign rise_start = btn_start & ~start_prev;
  assign rise_fire  = btn_fire  & ~fire_prev;
  assign sweep_inc  = sweep_cnt + SW'(1);
  assign state      = st;

  // Triangle fold: positions 8..15 map to 7..0, which is ~pos[2:0].
  function automatic logic [2:0] level_of(input logic [3:0] p);
    return p[3] ? ~p[2:0] : p[2:0];
  endfunction

  // Thermometer bar, bit7 lit first.
  function automatic logic [7:0] bar_of(input logic [2:0] lvl);
    return 8'hFF << (3'd7 - lvl);
  endfunction

  // Input history for edge detection; starts high so held inputs give no edge.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      tick_prev  <= 1'b1;
      start_prev <= 1'b1;
      fire_prev  <= 1'b1;
    end else begin
      tick_prev  <= tick_in;
      start_prev <= btn_start;
      fire_prev  <= btn_fire;
    end
  end

  // Gauge FSM with registered outputs.
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      st         <= IDLE;
      pos        <= 4'd0;
      power      <= 3'd0;
      timeout    <= 1'b0;
      shot_valid <= 1'b0;
      led_en     <= 1'b0;
      div_cnt    <= '0;
      sweep_cnt  <= '0;
    end else begin
      case (st)
        IDLE: begin
          led_en <= ATTRACT;
          if (rise_start) begin
            st        <= SWEEP;
            led_en    <= 1'b1;
            pos       <= 4'd0;
            div_cnt   <= '0;
            sweep_cnt <= '0;
            timeout   <= 1'b0;
          end else if (ATTRACT && rise_tick) begin
            pos <= pos + 4'd1;
          end
        end
        SWEEP: begin
          if (rise_fire) begin
            // Fire wins over any step or timeout landing on the same cycle.
            st         <= LOCK;
            power      <= level_of(pos);
            timeout    <= 1'b0;
            shot_valid <= 1'b1;
            led_en     <= 1'b0;
          end else if (rise_tick) begin
            if (div_cnt == DIV_LAST) begin
              div_cnt <= '0;
              pos     <= pos + 4'd1;
              if (pos == 4'd15) begin
                sweep_cnt <= sweep_inc;
                if (sweep_inc == SWEEP_MAX) begin
                  st         <= LOCK;
                  power      <= 3'd0;
                  timeout    <= 1'b1;
                  shot_valid <= 1'b1;
                  led_en     <= 1'b0;
                end
              end
            end else begin
              div_cnt <= div_cnt + DW'(1);
            end
          end
        end
        LOCK: begin
          if (shot_valid && shot_ready) begin
            st         <= IDLE;
            shot_valid <= 1'b0;
            led_en     <= ATTRACT;
          end
        end
        default: begin
          st         <= IDLE;
          shot_valid <= 1'b0;
          led_en     <= 1'b0;
        end
      endcase
    end
  end

  // Bar decode from registered state, position and captured power.
  always_comb begin
    bar = 8'h00;
    case (st)
      SWEEP:   bar = bar_of(level_of(pos));
      LOCK:    bar = bar_of(power);
      IDLE:    if (ATTRACT && led_en) bar = bar_of(level_of(pos));
      default: bar = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_power_gauge_ctrl.sv
// tb_power_gauge_ctrl: self-checking bench for power_gauge_ctrl.
// Inputs change on the falling edge; outputs are checked 1 unit after the
// rising edge or on the falling edge. Delivered shots are checked against
// a queue of {timeout, power} values pushed when the lock is provoked.
module tb_power_gauge_ctrl;

  logic       CLK = 1'b0;
  logic       nrst = 1'b0;
  logic       tick_in = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_fire = 1'b0;
  logic       shot_ready = 1'b0;
  logic       led_en;
  logic [3:0] pos;
  logic [7:0] bar;
  logic [2:0] power;
  logic       shot_valid;
  logic       timeout;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];

  power_gauge_ctrl #(.TICK_DIV(4), .MAX_SWEEPS(3)) dut (
    .CLK(CLK), .nrst(nrst), .tick_in(tick_in), .btn_start(btn_start),
    .btn_fire(btn_fire), .shot_ready(shot_ready), .led_en(led_en),
    .pos(pos), .bar(bar), .power(power), .shot_valid(shot_valid),
    .timeout(timeout), .state(state)
  );

  // Clock.
  always #5 CLK = ~CLK;

  // Reference level and bar mapping.
  function automatic logic [2:0] ref_level(input int p);
    int l;
    l = (p < 8) ? p : 15 - p;
    return 3'(l);
  endfunction

  function automatic logic [7:0] ref_bar(input logic [2:0] l);
    logic [7:0] ones;
    ones = 8'hFF;
    return ones << (7 - int'(l));
  endfunction

  // Driver: n tick rising edges, each one CLK high then one CLK low.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK) tick_in = 1'b1;
      @(negedge CLK) tick_in = 1'b0;
    end
  endtask

  // Driver: one start press, checking the 1-CLK edge-to-state latency.
  task automatic press_start();
    @(negedge CLK) btn_start = 1'b1;
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 2'd1 || pos !== 4'd0 || bar !== 8'h80 || led_en !== 1'b1) begin
      n_fail++;
      $display("FAIL start_to_sweep: state=%0d pos=%0d bar=%h led_en=%b, want 1 0 80 1",
               state, pos, bar, led_en);
    end
    @(negedge CLK) btn_start = 1'b0;
  endtask

  // Handshake: hold ready low for 'wait_cyc' cycles, then accept one shot.
  task automatic handshake(input int wait_cyc);
    logic [2:0] p0;
    p0 = power;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge CLK);
      n_tests++;
      if (shot_valid !== 1'b1 || power !== p0 || state !== 2'd2) begin
        n_fail++;
        $display("FAIL hold_valid: cyc=%0d valid=%b power=%0d state=%0d, want 1 %0d 2",
                 i, shot_valid, power, state, p0);
      end
    end
    @(negedge CLK) shot_ready = 1'b1;
    n_tests++;
    if (shot_valid !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL shot_present: valid=%b queued=%0d, want valid=1 queued>0",
               shot_valid, exp_q.size());
    end else begin
      logic [3:0] e;
      e = exp_q.pop_front();
      if ({timeout, power} !== e) begin
        n_fail++;
        $display("FAIL shot_data: timeout=%b power=%0d, want timeout=%b power=%0d",
                 timeout, power, e[3], e[2:0]);
      end
    end
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 2'd0 || shot_valid !== 1'b0 || power !== p0) begin
      n_fail++;
      $display("FAIL after_accept: state=%0d valid=%b power=%0d, want 0 0 %0d",
               state, shot_valid, power, p0);
    end
    @(negedge CLK) shot_ready = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    btn_start = 1'b1;
    #1;
    n_tests++;
    if (state !== 2'd0 || pos !== 4'd0 || power !== 3'd0 || shot_valid !== 1'b0 ||
        timeout !== 1'b0 || led_en !== 1'b0 || bar !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_values: state=%0d pos=%0d power=%0d valid=%b to=%b led=%b bar=%h, want all 0",
               state, pos, power, shot_valid, timeout, led_en, bar);
    end
    repeat (2) @(negedge CLK);
    nrst = 1'b1;
    repeat (4) @(negedge CLK);
    n_tests++;
    if (state !== 2'd0 || shot_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL held_start_no_edge: state=%0d valid=%b, want 0 0", state, shot_valid);
    end
`ifndef GAUGE_ATTRACT_EN
    n_tests++;
    if (bar !== 8'h00 || led_en !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_bar: bar=%h led_en=%b, want 00 0", bar, led_en);
    end
`endif
    btn_start = 1'b0;
    @(negedge CLK);
    press_start();
  endtask

  task automatic test_sweep_fire();
    tick_n(20);
    n_tests++;
    if (pos !== 4'd5 || bar !== ref_bar(ref_level(5)) || state !== 2'd1) begin
      n_fail++;
      $display("FAIL sweep_pos5: pos=%0d bar=%h state=%0d, want 5 %h 1",
               pos, bar, state, ref_bar(ref_level(5)));
    end
    // Start is ignored while sweeping.
    @(negedge CLK) btn_start = 1'b1;
    @(negedge CLK) btn_start = 1'b0;
    n_tests++;
    if (pos !== 4'd5 || state !== 2'd1) begin
      n_fail++;
      $display("FAIL start_ignored: pos=%0d state=%0d, want 5 1", pos, state);
    end
    @(negedge CLK) btn_fire = 1'b1;
    exp_q.push_back({1'b0, ref_level(5)});
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 2'd2 || power !== 3'd5 || shot_valid !== 1'b1 || timeout !== 1'b0 ||
        led_en !== 1'b0 || bar !== 8'hFC) begin
      n_fail++;
      $display("FAIL fire_lock: state=%0d power=%0d valid=%b to=%b led=%b bar=%h, want 2 5 1 0 0 fc",
               state, power, shot_valid, timeout, led_en, bar);
    end
    @(negedge CLK) btn_fire = 1'b0;
    handshake(0);
  endtask

  task automatic test_fire_on_step();
    press_start();
    tick_n(12 * 4 + 3);
    @(negedge CLK);
    tick_in  = 1'b1;
    btn_fire = 1'b1;
    exp_q.push_back({1'b0, ref_level(12)});
    @(posedge CLK); #1;
    n_tests++;
    if (state !== 2'd2 || power !== 3'd3 || pos !== 4'd12 || bar !== 8'hF0) begin
      n_fail++;
      $display("FAIL fire_beats_step: state=%0d power=%0d pos=%0d bar=%h, want 2 3 12 f0",
               state, power, pos, bar);
    end
    @(negedge CLK);
    tick_in  = 1'b0;
    btn_fire = 1'b0;
    handshake(2);
  endtask

  task automatic test_timeout();
    press_start();
    tick_n(3 * 16 * 4 - 1);
    n_tests++;
    if (state !== 2'd1 || pos !== 4'd15) begin
      n_fail++;
      $display("FAIL pre_timeout: state=%0d pos=%0d, want 1 15", state, pos);
    end
    tick_n(1);
    exp_q.push_back({1'b1, 3'd0});
    n_tests++;
    if (state !== 2'd2 || power !== 3'd0 || timeout !== 1'b1 || shot_valid !== 1'b1 ||
        pos !== 4'd0 || bar !== 8'h80) begin
      n_fail++;
      $display("FAIL auto_lock: state=%0d power=%0d to=%b valid=%b pos=%0d bar=%h, want 2 0 1 1 0 80",
               state, power, timeout, shot_valid, pos, bar);
    end
    // Fire is ignored in LOCK.
    @(negedge CLK) btn_fire = 1'b1;
    @(negedge CLK) btn_fire = 1'b0;
    n_tests++;
    if (power !== 3'd0 || timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL fire_in_lock: power=%0d to=%b, want 0 1", power, timeout);
    end
    handshake(10);
  endtask

  task automatic test_reset_in_lock();
    press_start();
    tick_n(8);
    @(negedge CLK) btn_fire = 1'b1;
    @(negedge CLK) btn_fire = 1'b0;
    n_tests++;
    if (state !== 2'd2 || shot_valid !== 1'b1 || power !== 3'd2) begin
      n_fail++;
      $display("FAIL lock_before_rst: state=%0d valid=%b power=%0d, want 2 1 2",
               state, shot_valid, power);
    end
    #2 nrst = 1'b0;
    #1;
    n_tests++;
    if (state !== 2'd0 || pos !== 4'd0 || power !== 3'd0 || shot_valid !== 1'b0 ||
        timeout !== 1'b0 || led_en !== 1'b0 || bar !== 8'h00) begin
      n_fail++;
      $display("FAIL async_rst: state=%0d pos=%0d power=%0d valid=%b to=%b led=%b bar=%h, want all 0",
               state, pos, power, shot_valid, timeout, led_en, bar);
    end
    @(negedge CLK) nrst = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_idle_ticks();
    tick_n(9);
`ifdef GAUGE_ATTRACT_EN
    n_tests++;
    if (pos !== 4'd9 || led_en !== 1'b1 || bar !== ref_bar(ref_level(9))) begin
      n_fail++;
      $display("FAIL attract: pos=%0d led=%b bar=%h, want 9 1 %h",
               pos, led_en, bar, ref_bar(ref_level(9)));
    end
`else
    n_tests++;
    if (pos !== 4'd0 || led_en !== 1'b0 || bar !== 8'h00 || state !== 2'd0) begin
      n_fail++;
      $display("FAIL idle_hold: pos=%0d led=%b bar=%h state=%0d, want 0 0 00 0",
               pos, led_en, bar, state);
    end
`endif
    press_start();
  endtask

  initial begin
    test_reset();
    test_sweep_fire();
    test_fire_on_step();
    test_timeout();
    test_reset_in_lock();
    test_idle_ticks();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drained: %0d left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
